// File: rtl/als_sample_scheduler.sv
// als_sample_scheduler
//   Schedules periodic ambient-light-sensor conversions on an external SPI
//   read engine. One spi_start pulse is issued per sample period. The
//   returned 16-bit frame is checked for framing, and the 8-bit light value
//   is extracted. 2^k samples are averaged, and each result is offered on a
//   valid/ready output.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   enable              run periodic sampling while high
//   avg_log2[2:0]       averaging exponent k (clamped to MAX_AVG_LOG2)
//   spi_start           one-cycle frame start pulse to the SPI engine
//   spi_busy            engine busy; a tick seen while busy is skipped
//   spi_done            one-cycle frame-complete pulse
//   spi_frame[15:0]     received frame: [15:13]=0, [12:5]=data, [4]=x, [3:0]=0
//   out_data[7:0]       averaged light value
//   out_last[7:0]       most recent valid raw sample
//   out_valid/out_ready result handshake
//   frame_err           sticky: frame failed the framing check
//   timeout_err         sticky: engine did not answer in TIMEOUT_CYCLES
//   overrun             sticky: an unaccepted result was overwritten
//   clr_err             clears the sticky flags (a same-cycle set event wins)
module als_sample_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned MAX_AVG_LOG2   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  avg_log2,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [15:0] spi_frame,
  output logic [7:0]  out_data,
  output logic [7:0]  out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        overrun,
  input  logic        clr_err
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW = 8 + MAX_AVG_LOG2;
  localparam int unsigned CW = MAX_AVG_LOG2 + 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    K_MAX     = 3'(MAX_AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_WAIT_DONE,
    S_CHECK,
    S_ACCUM,
    S_PRESENT
  } state_t;

  state_t          state;
  state_t          state_next;
  state_t          ret_state;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   tcnt;
  logic [15:0]     frame_q;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [2:0]      k_reg;
  logic [2:0]      k_in;
  logic [2:0]      k_eff;
  logic            tick;
  logic            frame_bad;
  logic [7:0]      frame_data;
  logic            frame_unused;
  logic            block_full;
  logic            timeout_evt;
  logic            frame_evt;
  logic            ovr_evt;

  assign tick         = enable && (pcnt == PCNT_LAST);
  assign frame_bad    = (|frame_q[15:13]) || (|frame_q[3:0]);
  assign frame_data   = frame_q[12:5];
  assign frame_unused = frame_q[4];

  // k is latched with the first sample of a block, so a change of avg_log2
  // mid-block only affects the next block.
  assign k_in       = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
  assign k_eff      = (cnt == '0) ? k_in : k_reg;
  assign cnt_inc    = cnt + CW'(1);
  assign block_full = (cnt_inc == (CW'(1) << k_eff));

  // After any conversion finishes, drop to IDLE if sampling was disabled
  // meanwhile.
  assign ret_state = enable ? S_WAIT_TICK : S_IDLE;

  assign timeout_evt = (state == S_WAIT_DONE) && !spi_done && (tcnt == TCNT_LAST);
  assign frame_evt   = (state == S_CHECK) && frame_bad;
  assign ovr_evt     = (state == S_PRESENT) && out_valid && !out_ready;

  // Gated with rst so a pending START never leaks out during the reset cycle.
  assign spi_start = (state == S_START) && !rst;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (enable) state_next = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (!enable)                 state_next = S_IDLE;
        else if (tick && !spi_busy)  state_next = S_START;
      end
      S_START:     state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (spi_done)                state_next = S_CHECK;
        else if (tcnt == TCNT_LAST)  state_next = ret_state;
      end
      S_CHECK:     state_next = frame_bad ? ret_state : S_ACCUM;
      S_ACCUM:     state_next = block_full ? S_PRESENT : ret_state;
      S_PRESENT:   state_next = ret_state;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pcnt        <= '0;
      tcnt        <= '0;
      frame_q     <= '0;
      acc         <= '0;
      cnt         <= '0;
      k_reg       <= '0;
      out_data    <= '0;
      out_last    <= '0;
      out_valid   <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state <= state_next;

      if (!enable || (pcnt == PCNT_LAST)) pcnt <= '0;
      else                                pcnt <= pcnt + PW'(1);

      if (state == S_START)          tcnt <= '0;
      else if (state == S_WAIT_DONE) tcnt <= tcnt + TW'(1);

      if ((state == S_WAIT_DONE) && spi_done) frame_q <= spi_frame;

      if ((state == S_CHECK) && !frame_bad) out_last <= frame_data;

      case (state)
        S_IDLE: begin
          acc <= '0;
          cnt <= '0;
        end
        S_ACCUM: begin
          acc <= acc + AW'(frame_data);
          cnt <= cnt_inc;
          if (cnt == '0) k_reg <= k_in;
        end
        S_PRESENT: begin
          out_data <= 8'(acc >> k_reg);
          acc      <= '0;
          cnt      <= '0;
        end
        default: ;
      endcase

      // A new result in the same cycle as an accept keeps out_valid high.
      if (state == S_PRESENT) out_valid <= 1'b1;
      else if (out_ready)     out_valid <= 1'b0;

      frame_err   <= (frame_err   && !clr_err) || frame_evt;
      timeout_err <= (timeout_err && !clr_err) || timeout_evt;
      overrun     <= (overrun     && !clr_err) || ovr_evt;
    end
  end

endmodule

// File: tb/tb_als_sample_scheduler.sv
// tb_als_sample_scheduler
//   Self-checking bench for als_sample_scheduler. A small SPI engine model
//   answers each spi_start with a frame after a random delay (or never). A
//   transaction-level reference model derives the expected average, last
//   sample, sticky flags, start spacing and result latency.
module tb_als_sample_scheduler;

  localparam int unsigned P    = 64;
  localparam int unsigned T    = 40;
  localparam int unsigned MAXK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  avg_log2;
  logic        spi_start;
  logic        spi_busy;
  logic        spi_done;
  logic [15:0] spi_frame;
  logic [7:0]  out_data;
  logic [7:0]  out_last;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic        timeout_err;
  logic        overrun;
  logic        clr_err;

  int unsigned n_checks   = 0;
  int unsigned n_fail     = 0;
  int unsigned cyc        = 0;
  int unsigned prev_start = 0;

  // Reference model state
  int unsigned m_sum  = 0;
  int unsigned m_cnt  = 0;
  int unsigned m_k    = 0;
  int unsigned m_data = 0;
  int unsigned m_last = 0;
  bit          m_valid = 0;
  bit          e_ferr  = 0;
  bit          e_terr  = 0;
  bit          e_ovr   = 0;

  als_sample_scheduler #(
    .PERIOD_CYCLES (P),
    .TIMEOUT_CYCLES(T),
    .MAX_AVG_LOG2  (MAXK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .avg_log2   (avg_log2),
    .spi_start  (spi_start),
    .spi_busy   (spi_busy),
    .spi_done   (spi_done),
    .spi_frame  (spi_frame),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid",   out_valid,   m_valid);
    check_eq("out_data",    out_data,    m_data);
    check_eq("out_last",    out_last,    m_last);
    check_eq("frame_err",   frame_err,   e_ferr);
    check_eq("timeout_err", timeout_err, e_terr);
    check_eq("overrun",     overrun,     e_ovr);
  endtask

  function automatic logic [15:0] good_frame(input logic [7:0] d, input logic b4);
    return {3'b000, d, b4, 4'b0000};
  endfunction

  // Waits (bounded) for spi_start and checks its spacing from the previous
  // start or reference point; gap 0 skips the spacing check.
  task automatic wait_start(input int unsigned gap);
    bit seen = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check_eq("start_seen", seen, 1);
    if (seen && gap != 0) check_eq("start_gap", cyc - prev_start, gap);
    prev_start = cyc;
  endtask

  // Called on the negedge where spi_start is visible.
  task automatic serve(input logic [15:0] frame, input int unsigned delay, input bit respond);
    bit          had_valid;
    bit          bad;
    logic [7:0]  d;
    if (!respond) begin
      @(negedge clk);
      check_eq("start_pulse", spi_start, 0);
      repeat (T - 1) @(negedge clk);
      check_eq("timeout_early", timeout_err, e_terr);
      @(negedge clk);
      e_terr = 1;
      check_eq("timeout_set", timeout_err, 1);
    end else begin
      spi_busy = 1;
      @(negedge clk);
      check_eq("start_pulse", spi_start, 0);
      repeat (delay) @(negedge clk);
      spi_done  = 1;
      spi_frame = frame;
      @(negedge clk);
      spi_done  = 0;
      spi_busy  = 0;
      spi_frame = 16'($urandom);

      had_valid = m_valid;
      bad = (frame[15:13] != 3'b000) || (frame[3:0] != 4'b0000);
      d   = frame[12:5];
      if (bad) begin
        e_ferr = 1;
      end else begin
        m_last = d;
        if (m_cnt == 0) m_k = (avg_log2 > MAXK) ? MAXK : avg_log2;
        m_sum += d;
        m_cnt++;
        if (m_cnt == (1 << m_k)) begin
          if (m_valid && !out_ready) e_ovr = 1;
          m_valid = 1;
          m_data  = m_sum >> m_k;
          m_sum   = 0;
          m_cnt   = 0;
        end
      end

      repeat (2) @(negedge clk);
      check_eq("latency_pre", out_valid, had_valid);
      @(negedge clk);
      check_outputs();
      if (out_ready) begin
        @(negedge clk);
        m_valid = 0;
        check_eq("valid_drop", out_valid, 0);
      end
    end
  endtask

  task automatic conv(input logic [15:0] frame, input int unsigned delay, input bit respond,
                      input int unsigned gap);
    wait_start(gap);
    serve(frame, delay, respond);
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    e_ferr = 0;
    e_terr = 0;
    e_ovr  = 0;
    check_eq("clr_frame_err",   frame_err,   0);
    check_eq("clr_timeout_err", timeout_err, 0);
    check_eq("clr_overrun",     overrun,     0);
  endtask

  initial begin
    logic [15:0] f;
    int unsigned r;
    int unsigned gap;
    bit          rdy;

    rst       = 1;
    enable    = 0;
    avg_log2  = 3'd0;
    spi_busy  = 0;
    spi_done  = 0;
    spi_frame = '0;
    out_ready = 1;
    clr_err   = 0;
    repeat (3) @(negedge clk);
    check_outputs();
    check_eq("reset_start", spi_start, 0);

    rst    = 0;
    enable = 1;
    prev_start = cyc;

    // Pass-through, k=0
    conv(16'h0A60, 3, 1, P);
    check_eq("pt_data", out_data, 8'h53);
    check_eq("pt_last", out_last, 8'h53);
    conv(16'h0A60, 5, 1, P);

    // Averaging, k=2: (0x10+0x20+0x30+0x41)>>2 = 0x28
    avg_log2 = 3'd2;
    conv(16'h0200, 1, 1, P);
    conv(16'h0400, 2, 1, P);
    conv(16'h0600, 0, 1, P);
    conv(16'h0820, 7, 1, P);
    check_eq("avg_data", out_data, 8'h28);
    check_eq("avg_last", out_last, 8'h41);

    // Framing error inside a k=1 block: (0x10+0x53)>>1 = 0x31
    avg_log2 = 3'd1;
    conv(16'h0200, 2, 1, P);
    conv(16'h8A60, 2, 1, P);
    check_eq("ferr_set", frame_err, 1);
    clear_flags();
    conv(16'h0A60, 4, 1, P);
    check_eq("ferr_avg", out_data, 8'h31);

    // Timeout, then normal operation resumes on the next tick
    avg_log2 = 3'd0;
    conv(16'h0000, 0, 0, P);
    clear_flags();
    conv(16'h0A60, 2, 1, P);

    // Backpressure
    out_ready = 0;
    conv(16'h0200, 1, 1, P);
    conv(16'h0400, 4, 1, P);
    check_eq("bp_overrun", overrun, 1);
    check_eq("bp_data", out_data, 8'h20);
    out_ready = 1;
    @(negedge clk);
    m_valid = 0;
    check_eq("bp_drop", out_valid, 0);
    clear_flags();

    // Disable with a partial block: accumulator restarts on re-enable
    avg_log2 = 3'd1;
    conv(16'h0200, 2, 1, P);
    enable = 0;
    repeat (4) @(negedge clk);
    enable = 1;
    prev_start = cyc;
    m_sum = 0;
    m_cnt = 0;
    conv(16'h0400, 3, 1, P);
    conv(16'h0600, 3, 1, P);
    check_eq("en_avg", out_data, 8'h28);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      gap = P;
      if ($urandom_range(0, 9) == 0) begin
        spi_busy = 1;
        repeat (P) @(negedge clk);
        spi_busy = 0;
        gap = 2 * P;
      end
      avg_log2 = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      if (rdy) m_valid = 0;
      out_ready = rdy;
      r = $urandom_range(0, 15);
      if (r == 0) begin
        conv(16'h0000, 0, 0, gap);
      end else begin
        if (r <= 2) begin
          f = 16'($urandom);
          if (f[15:13] == 3'b000 && f[3:0] == 4'b0000) f[15] = 1'b1;
        end else begin
          f = good_frame(8'($urandom), 1'($urandom));
        end
        conv(f, $urandom_range(0, 12), 1, gap);
      end
      if ((e_ferr || e_terr || e_ovr) && ($urandom_range(0, 1) == 1)) clear_flags();
    end

    // Reset during WAIT_DONE
    out_ready = 0;
    avg_log2  = 3'd0;
    conv(16'h0A60, 2, 1, P);
    conv(16'h8A60, 2, 1, P);
    wait_start(P);
    spi_busy = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    m_sum = 0; m_cnt = 0; m_k = 0; m_data = 0; m_last = 0; m_valid = 0;
    e_ferr = 0; e_terr = 0; e_ovr = 0;
    check_outputs();
    check_eq("rst_start", spi_start, 0);
    rst       = 0;
    spi_busy  = 0;
    out_ready = 1;
    prev_start = cyc;
    conv(16'h0A60, 2, 1, P);
    check_eq("post_rst_data", out_data, 8'h53);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/als_sample_scheduler.md
Name: als_sample_scheduler

Overview:
- Sequences periodic light-sensor conversions over a separate SPI read engine.
- Issues one start pulse per sample period and captures the 16-bit frame the engine returns.
- Validates the frame format, extracts the 8-bit light value and averages 2^k samples.
- Presents each result on a valid/ready output, with error and overrun flags.

Parameters:
- PERIOD_CYCLES, 100000: clk cycles between conversion starts (1 ms at 100 MHz); minimum 64.
- TIMEOUT_CYCLES, 2048: maximum clk cycles allowed from spi_start to spi_done.
- MAX_AVG_LOG2, 4: largest supported averaging exponent.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous active-high reset
- enable  in  1  run periodic sampling while high
- avg_log2  in  3  averaging exponent k; values above MAX_AVG_LOG2 are clamped to MAX_AVG_LOG2
- spi_start  out  1  one-cycle pulse that starts an SPI frame
- spi_busy  in  1  engine busy
- spi_done  in  1  one-cycle pulse: frame complete
- spi_frame  in  16  received frame, MSB first
- out_data  out  8  averaged light value
- out_last  out  8  most recent valid raw sample
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- frame_err  out  1  sticky: bad frame framing bits
- timeout_err  out  1  sticky: engine never answered
- overrun  out  1  sticky: result dropped because previous one not accepted
- clr_err  in  1  clears all sticky flags

Behaviour:
- Clocking and reset:
  - Single clock domain on clk; reset is synchronous and active-high.
  - All state updates on posedge clk.
- Reset values:
  - spi_start, out_valid, frame_err, timeout_err, overrun = 0.
  - out_data, out_last = 0.
  - Accumulator, sample count, period counter and timeout counter = 0.
  - FSM = IDLE.
- Period counter:
  - Free-runs 0..PERIOD_CYCLES-1 while enable=1.
  - Emits a tick when it wraps to 0.
  - Held at 0 while enable=0.
- Frame format: spi_frame[15:13] and [3:0] must be zero; data = spi_frame[12:5]; spi_frame[4] is don't-care.
- FSM states and transitions:
  - IDLE: wait for enable=1 → WAIT_TICK.
  - WAIT_TICK:
    - enable=0 → IDLE.
    - tick and spi_busy=0 → START.
    - tick while spi_busy=1: that tick is skipped; stay in WAIT_TICK.
  - START: spi_start=1 for exactly one cycle; timeout counter cleared → WAIT_DONE.
  - WAIT_DONE:
    - spi_done=1 → CHECK (frame registered on the same edge).
    - Timeout counter reaches TIMEOUT_CYCLES-1 → set timeout_err → WAIT_TICK.
    - spi_done in that same cycle takes priority over the timeout.
  - CHECK:
    - Framing bits nonzero → set frame_err, discard sample → WAIT_TICK.
    - Otherwise out_last <= data → ACCUM.
  - ACCUM:
    - Accumulator (8+MAX_AVG_LOG2 bits) += data; count++.
    - count reaches 2^k → PRESENT; otherwise → WAIT_TICK.
  - PRESENT:
    - out_data <= accumulator >> k (truncating).
    - If out_valid=1 and out_ready=0 in this cycle: set overrun; new value replaces the old.
    - out_valid <= 1; accumulator and count cleared → WAIT_TICK.
- Latency: spi_done to out_valid is 3 cycles when the sample completes a block (CHECK, ACCUM, PRESENT).
- Output handshake:
  - out_valid stays high until a cycle with out_valid & out_ready, then falls on the next edge.
  - A PRESENT in that same cycle wins: out_valid stays 1 with the new data, and overrun is not set.
- Averaging exponent:
  - avg_log2 is sampled when the accumulator is empty (count=0).
  - Changes mid-block take effect at the next block.
  - k=0 gives pass-through: every valid sample produces a result.
- enable=0 mid-frame:
  - FSM still waits for spi_done or the timeout, then goes to IDLE.
  - Accumulator is cleared on entry to IDLE; out_valid and the sticky flags are unaffected.
- Sticky flags:
  - clr_err=1 clears them.
  - A set event in the same cycle as clr_err wins (flag = 1).
- rst mid-operation: everything returns to reset values on the next edge; spi_start is never asserted in the reset cycle.

Test Plan:
- Pass-through: k=0, PERIOD_CYCLES=64, frame 0x0A60 (data 0x53), out_ready=1 → one spi_start per 64 cycles; out_data=out_last=0x53 three cycles after spi_done; no flags set.
- Averaging: k=2, data sequence 0x10, 0x20, 0x30, 0x41 → exactly one out_valid with out_data=0x28 (0xA1>>2); out_last=0x41.
- Framing: frame 0x8A60 → frame_err=1, no out_valid, accumulator count unchanged; next good frame 0x0A60 is averaged normally; clr_err clears frame_err.
- Timeout: engine never pulses spi_done → timeout_err after TIMEOUT_CYCLES cycles; next tick issues a new spi_start.
- Backpressure: k=0, out_ready=0, two good frames 0x0200 (data 0x10) then 0x0400 (data 0x20) → overrun=1, out_data=0x20; raising out_ready drops out_valid one cycle later.
- Reset mid-frame: assert rst during WAIT_DONE → all outputs 0 next edge; after release the first spi_start comes only after a full period tick.
